// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-channel fixed-latency data memory responder
//
// Purpose: memory-side endpoint answering per-channel read and write requests.
// Each channel owns an independent read engine and write engine
// (IDLE/WAIT/RESP/RELEASE). A response strobe rises LATENCY edges after
// acceptance, counting the accepting edge. A host load port preloads contents.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset (clears memory too)
//   mem_read_valid      per-channel read request
//   mem_read_address    packed per-channel read address
//   mem_read_ready      per-channel one-cycle read response strobe
//   mem_read_data       packed per-channel read data, meaningful while ready=1
//   mem_write_valid     per-channel write request
//   mem_write_address   packed per-channel write address
//   mem_write_data      packed per-channel write data
//   mem_write_ready     per-channel one-cycle write acknowledge strobe
//   load_enable/address/data  host preload port
module data_mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]           mem_read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]           mem_write_ready,
  input  logic                              load_enable,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         DIRECT   = (LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RELEASE} state_t;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  state_t               rd_state_q [NUM_CHANNELS];
  logic [3:0]           rd_cnt_q   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] rd_addr_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] rd_data_q  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] rd_ready_q;

  state_t               wr_state_q [NUM_CHANNELS];
  logic [3:0]           wr_cnt_q   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] wr_addr_q  [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wr_data_q  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] wr_ready_q;

  // "fire" marks the edge that enters RESP. With LATENCY=1 that is the
  // accepting edge itself, so the live request fields are used instead of
  // the (not yet captured) registers.
  logic [NUM_CHANNELS-1:0] rd_fire, wr_fire;
  logic [ADDR_BITS-1:0]    rd_fire_addr [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    wr_fire_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    wr_fire_data [NUM_CHANNELS];

  always_comb begin
    rd_fire = '0;
    wr_fire = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_fire[c] = (rd_state_q[c] == S_IDLE && mem_read_valid[c] && DIRECT) ||
                   (rd_state_q[c] == S_WAIT && rd_cnt_q[c] == 4'd0);
      wr_fire[c] = (wr_state_q[c] == S_IDLE && mem_write_valid[c] && DIRECT) ||
                   (wr_state_q[c] == S_WAIT && wr_cnt_q[c] == 4'd0);
      rd_fire_addr[c] = (rd_state_q[c] == S_IDLE) ?
                        mem_read_address[c*ADDR_BITS +: ADDR_BITS] : rd_addr_q[c];
      wr_fire_addr[c] = (wr_state_q[c] == S_IDLE) ?
                        mem_write_address[c*ADDR_BITS +: ADDR_BITS] : wr_addr_q[c];
      wr_fire_data[c] = (wr_state_q[c] == S_IDLE) ?
                        mem_write_data[c*DATA_BITS +: DATA_BITS] : wr_data_q[c];
    end
  end

  // Later assignments win: load first, then channels in ascending order, so
  // the highest-index channel wins and any channel commit beats the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (load_enable) mem_q[load_address] <= load_data;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_fire[c]) mem_q[wr_fire_addr[c]] <= wr_fire_data[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rd_state_q[c] <= S_IDLE;
        rd_cnt_q[c]   <= '0;
        rd_addr_q[c]  <= '0;
        rd_data_q[c]  <= '0;
        wr_state_q[c] <= S_IDLE;
        wr_cnt_q[c]   <= '0;
        wr_addr_q[c]  <= '0;
        wr_data_q[c]  <= '0;
      end
      rd_ready_q <= '0;
      wr_ready_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        // Reads sample the array before this edge's commits (old data).
        if (rd_fire[c]) rd_data_q[c] <= mem_q[rd_fire_addr[c]];
        rd_ready_q[c] <= rd_fire[c];
        wr_ready_q[c] <= wr_fire[c];

        case (rd_state_q[c])
          S_IDLE: if (mem_read_valid[c]) begin
            rd_addr_q[c]  <= mem_read_address[c*ADDR_BITS +: ADDR_BITS];
            rd_cnt_q[c]   <= CNT_INIT;
            rd_state_q[c] <= DIRECT ? S_RESP : S_WAIT;
          end
          S_WAIT: if (rd_cnt_q[c] == 4'd0) rd_state_q[c] <= S_RESP;
                  else rd_cnt_q[c] <= rd_cnt_q[c] - 4'd1;
          S_RESP: rd_state_q[c] <= mem_read_valid[c] ? S_RELEASE : S_IDLE;
          S_RELEASE: if (!mem_read_valid[c]) rd_state_q[c] <= S_IDLE;
          default: rd_state_q[c] <= S_IDLE;
        endcase

        case (wr_state_q[c])
          S_IDLE: if (mem_write_valid[c]) begin
            wr_addr_q[c]  <= mem_write_address[c*ADDR_BITS +: ADDR_BITS];
            wr_data_q[c]  <= mem_write_data[c*DATA_BITS +: DATA_BITS];
            wr_cnt_q[c]   <= CNT_INIT;
            wr_state_q[c] <= DIRECT ? S_RESP : S_WAIT;
          end
          S_WAIT: if (wr_cnt_q[c] == 4'd0) wr_state_q[c] <= S_RESP;
                  else wr_cnt_q[c] <= wr_cnt_q[c] - 4'd1;
          S_RESP: wr_state_q[c] <= mem_write_valid[c] ? S_RELEASE : S_IDLE;
          S_RELEASE: if (!mem_write_valid[c]) wr_state_q[c] <= S_IDLE;
          default: wr_state_q[c] <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    mem_read_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      mem_read_data[c*DATA_BITS +: DATA_BITS] = rd_data_q[c];
    end
  end

  assign mem_read_ready  = rd_ready_q;
  assign mem_write_ready = wr_ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rv, rr, wv, wr_rdy;
  logic [31:0] raddr, rdata, waddr, wdata;
  logic        le;
  logic [7:0]  la, ld;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read_valid    (rv),
    .mem_read_address  (raddr),
    .mem_read_ready    (rr),
    .mem_read_data     (rdata),
    .mem_write_valid   (wv),
    .mem_write_address (waddr),
    .mem_write_data    (wdata),
    .mem_write_ready   (wr_rdy),
    .load_enable       (le),
    .load_address      (la),
    .load_data         (ld)
  );

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Every read response is matched against the oldest expected entry; a
  // response with nothing expected is itself an error.
  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (rr[c] === 1'b1) begin
        if (sb.size() == 0) begin
          check($sformatf("rd_unexpected_ch%0d", c), 32'(rr[c]), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rd_channel", 32'(c), 32'(e.ch));
          check($sformatf("rd_data_ch%0d", c), 32'(rdata[c*8 +: 8]), 32'(e.data));
        end
      end
    end
  end

  task automatic do_read(input int ch, input logic [7:0] addr, input logic [7:0] exp,
                         input string tag);
    sb.push_back('{ch, exp});
    rv[ch] = 1'b1;
    raddr[ch*8 +: 8] = addr;
    tick();
    check({tag, "_accept_edge"}, 32'(rr[ch]), 32'd0);
    tick();
    check({tag, "_ready"}, 32'(rr[ch]), 32'd1);
    rv[ch] = 1'b0;
    tick();
    check({tag, "_ready_drop"}, 32'(rr[ch]), 32'd0);
  endtask

  task automatic do_write(input int ch, input logic [7:0] addr, input logic [7:0] data,
                          input string tag);
    wv[ch] = 1'b1;
    waddr[ch*8 +: 8] = addr;
    wdata[ch*8 +: 8] = data;
    tick();
    check({tag, "_accept_edge"}, 32'(wr_rdy[ch]), 32'd0);
    tick();
    check({tag, "_ready"}, 32'(wr_rdy[ch]), 32'd1);
    wv[ch] = 1'b0;
    tick();
    check({tag, "_ready_drop"}, 32'(wr_rdy[ch]), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
    // Load during reset must be ignored.
    le = 1'b1; la = 8'h40; ld = 8'h77;
    tick();
    tick();
    check("rst_rd_ready", 32'(rr), 32'd0);
    check("rst_wr_ready", 32'(wr_rdy), 32'd0);
    check("rst_rd_data", rdata, 32'd0);

    // Preload.
    reset = 1'b0;
    la = 8'h10; ld = 8'h5A;
    tick();
    la = 8'h20; ld = 8'h99;
    tick();
    le = 1'b0;

    // Basic read timing, then a second read proves the engine is idle again.
    do_read(0, 8'h10, 8'h5A, "t1");
    do_read(0, 8'h40, 8'h00, "t1_reset_load_ignored");

    // Write then read from another channel.
    do_write(2, 8'h80, 8'h33, "t2_wr");
    do_read(3, 8'h80, 8'h33, "t2_rd");

    // Same-edge read/write to 0x20: read sees old data.
    sb.push_back('{1, 8'h99});
    wv[0] = 1'b1; waddr[7:0] = 8'h20; wdata[7:0] = 8'h11;
    rv[1] = 1'b1; raddr[15:8] = 8'h20;
    tick();
    tick();
    check("t3_wr_ready", 32'(wr_rdy[0]), 32'd1);
    check("t3_rd_ready", 32'(rr[1]), 32'd1);
    wv[0] = 1'b0; rv[1] = 1'b0;
    tick();
    do_read(1, 8'h20, 8'h11, "t3_after");

    // Write conflict: ch1, ch3 and the load port all hit 0x05 on one edge.
    wv[1] = 1'b1; waddr[15:8] = 8'h05; wdata[15:8] = 8'hAA;
    wv[3] = 1'b1; waddr[31:24] = 8'h05; wdata[31:24] = 8'hBB;
    tick();
    le = 1'b1; la = 8'h05; ld = 8'hCC;
    tick();
    check("t4_wr_ready", 32'(wr_rdy), 32'h0000_000A);
    le = 1'b0; wv = '0;
    tick();
    do_read(2, 8'h05, 8'hBB, "t4");

    // Hold valid after the response: one pulse only, address changes ignored.
    sb.push_back('{0, 8'h5A});
    rv[0] = 1'b1; raddr[7:0] = 8'h10;
    tick();
    tick();
    check("t5_ready", 32'(rr[0]), 32'd1);
    raddr[7:0] = 8'h20;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t5_hold_%0d", i), 32'(rr[0]), 32'd0);
    end
    rv[0] = 1'b0;
    tick();
    check("t5_released", 32'(rr[0]), 32'd0);
    do_read(0, 8'h20, 8'h11, "t5_next");

    // Abort a ch1 write in WAIT with reset.
    wv[1] = 1'b1; waddr[15:8] = 8'h90; wdata[15:8] = 8'h77;
    tick();
    reset = 1'b1; wv[1] = 1'b0;
    tick();
    check("t6_rd_ready", 32'(rr), 32'd0);
    check("t6_wr_ready", 32'(wr_rdy), 32'd0);
    check("t6_rd_data", rdata, 32'd0);
    reset = 1'b0;
    tick();
    check("t6_no_wr_pulse", 32'(wr_rdy), 32'd0);
    do_read(1, 8'h90, 8'h00, "t6_no_commit");
    do_read(0, 8'h10, 8'h00, "t6_mem_cleared");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
